// File: rtl/conv2d_window_mac_pkg.sv
// Shared definitions for the convolution window datapath: FSM state encodings
// and the default geometry and word widths.
package conv_defs;

  localparam int unsigned IMG_WIDTH_D   = 48;
  localparam int unsigned KERNEL_SIZE_D = 3;
  localparam int unsigned ADDR_W_D      = 14;
  localparam int unsigned DATA_W_D      = 8;
  localparam int unsigned ACC_W_D       = 21;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_DONE     = 3'd3,
    ST_WAIT_ACK = 3'd4
  } state_t;

endpackage

// File: rtl/conv2d_window_mac_mac_unit.sv
// Registered multiply-accumulate of an unsigned pixel and a signed kernel tap.
// o_acc includes the product accumulated on the coming edge, so the top can
// capture the final window sum on the same edge that adds the last tap.
module mac_unit
  import conv_defs::*;
#(
  parameter int unsigned DATA_W = DATA_W_D,
  parameter int unsigned ACC_W  = ACC_W_D
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clear,
  input  logic                     i_valid,
  input  logic [DATA_W-1:0]        i_pix,
  input  logic [DATA_W-1:0]        i_ker,
  output logic signed [ACC_W-1:0]  o_acc
);

  logic signed [2*DATA_W:0] w_pix_s;
  logic signed [2*DATA_W:0] w_ker_s;
  logic signed [2*DATA_W:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_acc_nxt;
  logic signed [ACC_W-1:0]  r_acc;

  // Pixel is zero-extended, kernel sign-extended; the exact product fits 2*DATA_W+1 bits.
  assign w_pix_s    = {{(DATA_W+1){1'b0}}, i_pix};
  assign w_ker_s    = {{(DATA_W+1){i_ker[DATA_W-1]}}, i_ker};
  assign w_prod     = w_pix_s * w_ker_s;
  assign w_prod_ext = ACC_W'(w_prod);

  always_comb begin
    w_acc_nxt = r_acc;
    if (i_valid) w_acc_nxt = r_acc + w_prod_ext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_acc <= '0;
    else if (i_clear) r_acc <= '0;
    else              r_acc <= w_acc_nxt;
  end

  assign o_acc = w_acc_nxt;

endmodule

// File: rtl/conv2d_window_mac.sv
// Window MAC engine: walks the KxK pixel window and kernel taps through two
// synchronous-read RAMs, accumulates, and hands the sum back with done/ack.
module conv2d_window_mac
  import conv_defs::*;
#(
  parameter int unsigned IMG_WIDTH   = IMG_WIDTH_D,
  parameter int unsigned KERNEL_SIZE = KERNEL_SIZE_D,
  parameter int unsigned ADDR_W      = ADDR_W_D,
  parameter int unsigned DATA_W      = DATA_W_D,
  parameter int unsigned ACC_W       = ACC_W_D
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [ADDR_W-1:0]        pix_addr,
  input  logic [ADDR_W-1:0]        kernel_addr,
  output logic [ADDR_W-1:0]        pix_rd_addr,
  input  logic [DATA_W-1:0]        pix_rd_data,
  output logic [ADDR_W-1:0]        ker_rd_addr,
  input  logic [DATA_W-1:0]        ker_rd_data,
  output logic                     done,
  input  logic                     ack,
  output logic signed [ACC_W-1:0]  result
);

  localparam int unsigned TAP_W = $clog2(KERNEL_SIZE*KERNEL_SIZE + 1);
  localparam int unsigned COL_W = $clog2(KERNEL_SIZE + 1);
  localparam logic [TAP_W-1:0]  LAST_TAP = TAP_W'(KERNEL_SIZE*KERNEL_SIZE - 1);
  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(KERNEL_SIZE - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_WIDTH);

  state_t                  r_state;
  logic [ADDR_W-1:0]       r_pix_addr;
  logic [ADDR_W-1:0]       r_ker_addr;
  logic [ADDR_W-1:0]       r_row_base;
  logic [COL_W-1:0]        r_col;
  logic [TAP_W-1:0]        r_tap;
  logic                    r_issue;
  logic                    r_rd_vld;
  logic                    r_done;
  logic signed [ACC_W-1:0] r_result;
  logic signed [ACC_W-1:0] w_acc;
  logic                    w_start;

  assign w_start = (r_state == ST_IDLE) && en;

  mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_start),
    .i_valid (r_rd_vld),
    .i_pix   (pix_rd_data),
    .i_ker   (ker_rd_data),
    .o_acc   (w_acc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pix_addr <= '0;
      r_ker_addr <= '0;
      r_row_base <= '0;
      r_col      <= '0;
      r_tap      <= '0;
      r_issue    <= 1'b0;
      r_rd_vld   <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
    end else begin
      r_done   <= 1'b0;
      r_rd_vld <= r_issue;
      case (r_state)
        ST_IDLE: begin
          if (en) begin
            r_row_base <= pix_addr;
            r_pix_addr <= pix_addr;
            r_ker_addr <= kernel_addr;
            r_col      <= '0;
            r_tap      <= '0;
            r_issue    <= 1'b1;
            r_state    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          // Last tap is already on the bus; one idle FETCH cycle lets its data arrive.
          if (r_tap == LAST_TAP) begin
            r_issue <= 1'b0;
            r_state <= ST_DRAIN;
          end else begin
            r_tap      <= r_tap + 1'b1;
            r_ker_addr <= r_ker_addr + 1'b1;
            r_issue    <= 1'b1;
            if (r_col == LAST_COL) begin
              r_col      <= '0;
              r_row_base <= r_row_base + ROW_STEP;
              r_pix_addr <= r_row_base + ROW_STEP;
            end else begin
              r_col      <= r_col + 1'b1;
              r_pix_addr <= r_pix_addr + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          r_result <= w_acc;
          r_done   <= 1'b1;
          r_state  <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= ack ? ST_IDLE : ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (ack) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pix_rd_addr = r_pix_addr;
  assign ker_rd_addr = r_ker_addr;
  assign done        = r_done;
  assign result      = r_result;

endmodule

// File: doc/conv2d_window_mac.md
# conv2d_window_mac

Datapath engine paired with the convolution address controller. It accepts a start request carrying a pixel base address and a kernel base address. It fetches the K×K pixel window and the matching kernel taps from two synchronous-read RAMs and multiply-accumulates them. It then returns the sum with a one-cycle `done` pulse and waits for the controller's `ack` before accepting the next window.

## Interface
- IMG_WIDTH, 48, pixel row pitch in words
- KERNEL_SIZE, 3, window edge K (taps = K×K)
- ADDR_W, 14, RAM address width
- DATA_W, 8, pixel/kernel word width
- ACC_W, 21, accumulator/result width; must be ≥ 2·DATA_W+1+ceil(log2(K×K))
- Clocking and reset: one clock; reset is asynchronous and active-high. Ports are `clk` and `rst`.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  start request, level; sampled only in IDLE
- pix_addr  in  ADDR_W  window top-left pixel address, sampled with `en`
- kernel_addr  in  ADDR_W  kernel tap-0 address, sampled with `en`
- pix_rd_addr  out  ADDR_W  pixel RAM read address
- pix_rd_data  in  DATA_W  pixel RAM data, unsigned, valid the cycle after address
- ker_rd_addr  out  ADDR_W  kernel RAM read address
- ker_rd_data  in  DATA_W  kernel RAM data, signed two's complement
- done  out  1  one-cycle pulse, result valid
- ack  in  1  controller acknowledge, sampled in DONE/WAIT_ACK
- result  out  ACC_W  signed window sum, held until next start

## Operation
- States: IDLE, FETCH, DRAIN, DONE, WAIT_ACK.
- **IDLE**
  - On `en`=1: latch both base addresses, clear the accumulator and tap index, and drive tap-0 addresses.
  - Go to FETCH.
- **Tap addressing** for tap t = r·K+c:
  - Pixel address: pix_base + r·IMG_WIDTH + c.
  - Kernel address: ker_base + t.
  - Row/column counters, no multiplier. Addresses are ADDR_W modulo (wrap silently).
- **FETCH:** advance one tap per cycle until tap K²−1 is driven, then go to DRAIN.
- **Accumulation pipeline:** a read-valid pipeline bit marks when RAM data is valid.
  - Each valid cycle: acc += $unsigned(pix) × $signed(ker), sign-extended to ACC_W.
  - No saturation: overflow wraps, which the ACC_W rule forbids.
- **DRAIN:** take the final product, load `result`, go to DONE.
- **DONE:** `done`=1 for exactly one cycle, then go to WAIT_ACK.
  - If `ack`=1 in DONE, go directly to IDLE.
- **WAIT_ACK:** stay until `ack`=1, then go to IDLE. `en` is ignored.
- `en` dropping mid-window does not abort the window.
- `ack` outside DONE/WAIT_ACK is ignored.
- `rst` at any time forces the reset state and discards the partial sum.

## Timing
- Reset values:
  - state=IDLE, done=0, result=0
  - pix_rd_addr=0, ker_rd_addr=0
  - accumulator=0, counters=0, valid pipe=0
- `en` sampled at edge E0. Tap t address is driven after E_t; its data is accumulated at E_{t+2}.
- For K=3:
  - FETCH covers E0→E8 address updates.
  - DRAIN is entered at E9.
  - `result` and `done` become 1 after E10: latency 10 cycles.
  - General latency: K²+1 cycles.
- Handshake with the controller:
  - `done` high in cycle E10–E11.
  - Controller registers `ack`=1 and `en`=0 at E11.
  - Block sees `ack` at E12 and returns to IDLE.
  - Controller re-raises `en` at E12; block starts at E13.
  - Window period: 13 cycles.
- `done` must never be high on two consecutive cycles; the controller counts every high cycle.
- Read addresses hold their last value outside FETCH.

## Structure
- Shared header `conv_defs` holds:
  - state encodings (3-bit)
  - default IMG_WIDTH/KERNEL_SIZE/ADDR_W/DATA_W/ACC_W
- One sub-module, `mac_unit`:
  - registered signed multiply-accumulate
  - inputs: clear, valid, pixel, kernel
  - output: ACC_W accumulator
- The FSM, address counters and valid pipeline stay in the top module.

## Test plan
- **Reset mid-FETCH:** assert `rst` at tap 4 → `done`=0, `result`=0, state IDLE; the next `en` yields a correct full window.
- **All-ones, center tap:** pix RAM all 1, kernel = identity (tap4=1, rest 0), base 0 → `done` after 10 cycles, `result`=1. Addresses seen: 0,1,2,48,49,50,96,97,98.
- **Extreme values:** pixels 255, kernel all −128 → `result`=−293760 with no wrap at ACC_W=21.
- **Back-to-back with the controller model:** two windows, second at base 1 → periods of exactly 13 cycles, one `done` pulse each, correct sums.
- **Delayed `ack`:** hold `ack`=0 for 20 cycles while `en`=1 → stays in WAIT_ACK, no new reads, `result` stable.
- **Address wrap:** pix_addr=16380 → pixel addresses wrap mod 16384 (16381, 16382, 44, …) with no X.
